// File: rtl/game_sequencer.sv
// Game-flow controller: advances wall depth on frame ticks, counts collision
// pixels at the goal depth, judges pass/fail and sequences walls and score.
module game_sequencer #(
  parameter int GOAL_DEPTH          = 60,
  parameter int GOAL_DEPTH_DELTA    = 10,
  parameter int MAX_WALL_DEPTH      = 75,
  parameter int FRAMES_PER_STEP     = 4,
  parameter int COLLISION_THRESHOLD = 500,
  parameter int HOLD_FRAMES         = 60,
  parameter int NUM_WALLS           = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       frame_tick_in,
  input  logic       start_in,
  input  logic       active_in,
  input  logic       is_collision_in,
  input  logic [7:0] player_depth_in,
  output logic [2:0] game_state_out,
  output logic [7:0] wall_depth_out,
  output logic [1:0] wall_sel_out,
  output logic [7:0] score_out,
  output logic       pass_pulse_out,
  output logic       fail_pulse_out
);

  localparam logic [2:0] ST_GAME_OVER = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_APPROACH  = 3'd2;
  localparam logic [2:0] ST_CHECK     = 3'd3;
  localparam logic [2:0] ST_PASS      = 3'd4;

  localparam logic [7:0]  GOAL_D    = 8'(GOAL_DEPTH);
  localparam logic [7:0]  MAX_D     = 8'(MAX_WALL_DEPTH);
  localparam logic [15:0] DIV_LAST  = 16'(FRAMES_PER_STEP - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_FRAMES - 1);
  localparam logic [15:0] THRESH    = 16'(COLLISION_THRESHOLD);
  localparam logic [1:0]  SEL_LAST  = 2'(NUM_WALLS - 1);
  // Acceptance window in 9 bits so the upper bound may exceed 255; lower clamps at 0.
  localparam int          LO_INT    = (GOAL_DEPTH > GOAL_DEPTH_DELTA) ? (GOAL_DEPTH - GOAL_DEPTH_DELTA) : 0;
  localparam logic [8:0]  WIN_LO    = 9'(LO_INT);
  localparam logic [8:0]  WIN_HI    = 9'(GOAL_DEPTH + GOAL_DEPTH_DELTA);

  logic [2:0]  state_q, state_d;
  logic [7:0]  depth_q, depth_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  score_q, score_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic [15:0] div_q, div_d;
  logic [15:0] coll_q, coll_d;
  logic [15:0] hold_q, hold_d;

  logic [7:0]  depth_inc;
  logic [8:0]  player_ext;
  logic        in_window;
  logic        step_due;

  assign depth_inc  = depth_q + 8'd1;
  assign player_ext = {1'b0, player_depth_in};
  assign in_window  = (player_ext >= WIN_LO) && (player_ext <= WIN_HI);
  assign step_due   = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    sel_d   = sel_q;
    score_d = score_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    div_d   = div_q;
    coll_d  = coll_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d = ST_APPROACH;
          depth_d = 8'd0;
          score_d = 8'd0;
          div_d   = 16'd0;
        end
      end
      ST_APPROACH: begin
        if (frame_tick_in) begin
          if (step_due) begin
            div_d   = 16'd0;
            depth_d = depth_inc;
            if (depth_inc == GOAL_D) begin
              state_d = ST_CHECK;
              coll_d  = 16'd0;
            end
          end else begin
            div_d = div_q + 16'd1;
          end
        end
      end
      ST_CHECK: begin
        // The tick cycle judges on the count so far; a collision on that cycle is dropped.
        if (frame_tick_in) begin
          if ((coll_q < THRESH) && in_window) begin
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
            pass_d  = 1'b1;
            state_d = ST_PASS;
            hold_d  = 16'd0;
          end else begin
            fail_d  = 1'b1;
            state_d = ST_GAME_OVER;
          end
        end else if (active_in && is_collision_in && (coll_q != 16'hFFFF)) begin
          coll_d = coll_q + 16'd1;
        end
      end
      ST_PASS: begin
        if (frame_tick_in) begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_APPROACH;
            depth_d = 8'd0;
            sel_d   = (sel_q == SEL_LAST) ? 2'd0 : sel_q + 2'd1;
            div_d   = 16'd0;
            hold_d  = 16'd0;
          end else begin
            hold_d = hold_q + 16'd1;
            if (step_due) begin
              div_d = 16'd0;
              if (depth_q < MAX_D) depth_d = depth_inc;
            end else begin
              div_d = div_q + 16'd1;
            end
          end
        end
      end
      ST_GAME_OVER: begin
        if (start_in) begin
          state_d = ST_APPROACH;
          depth_d = 8'd0;
          score_d = 8'd0;
          sel_d   = 2'd0;
          div_d   = 16'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      depth_q <= 8'd0;
      sel_q   <= 2'd0;
      score_q <= 8'd0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      div_q   <= 16'd0;
      coll_q  <= 16'd0;
      hold_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      sel_q   <= sel_d;
      score_q <= score_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      div_q   <= div_d;
      coll_q  <= coll_d;
      hold_q  <= hold_d;
    end
  end

  assign game_state_out = state_q;
  assign wall_depth_out = depth_q;
  assign wall_sel_out   = sel_q;
  assign score_out      = score_q;
  assign pass_pulse_out = pass_q;
  assign fail_pulse_out = fail_q;

endmodule
